// File: rtl/thor2022_pkg.sv
// Shared types for the Thor2022 sequential ALU: opcode and FSM state
// enumerations, plus small opcode-classification helpers.
// Optional divider feature macro: THOR2022_SEQ_ALU_DIV_EN.
package thor2022_pkg;

    localparam int OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_SLT  = 4'd8,
        OP_SLTU = 4'd9,
        OP_DIV  = 4'd10,
        OP_DIVU = 4'd11,
        OP_REM  = 4'd12,
        OP_REMU = 4'd13
    } seq_alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } seq_alu_state_t;

    // Divide-class opcode whose operands are treated as two's complement.
    function automatic logic is_signed_div(input seq_alu_op_t op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    // Divide-class opcode that returns the remainder as the primary result.
    function automatic logic is_rem_op(input seq_alu_op_t op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/thor2022_seq_div.sv
// Iterative radix-2 restoring divider for the Thor2022 sequential ALU.
// Works on operand magnitudes for WID cycles, then applies sign fix-up:
// quotient negative when operand signs differ, remainder takes the sign
// of the dividend. done_o pulses for one cycle after the last iteration.
// Only present when THOR2022_SEQ_ALU_DIV_EN is defined.
`ifdef THOR2022_SEQ_ALU_DIV_EN
module thor2022_seq_div #(
    parameter int WID = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start_i,
    input  logic           signed_i,
    input  logic [WID-1:0] a_i,
    input  logic [WID-1:0] b_i,
    output logic           done_o,
    output logic [WID-1:0] quot_o,
    output logic [WID-1:0] rem_o
);

    localparam int CW = $clog2(WID);

    logic [CW-1:0]  cnt_q;
    logic           busy_q;
    logic           done_q;
    logic           neg_quot_q;
    logic           neg_rem_q;
    logic [WID-1:0] rem_q;
    logic [WID-1:0] quo_q;
    logic [WID-1:0] dvs_q;

    logic           a_neg;
    logic           b_neg;
    logic [WID-1:0] a_mag;
    logic [WID-1:0] b_mag;
    logic [WID:0]   shifted;
    logic           q_bit;
    logic [WID-1:0] rem_step;
    logic [WID-1:0] quo_step;

    // Operand magnitudes captured at start.
    always_comb begin
        a_neg = signed_i & a_i[WID-1];
        b_neg = signed_i & b_i[WID-1];
        a_mag = a_neg ? ('0 - a_i) : a_i;
        b_mag = b_neg ? ('0 - b_i) : b_i;
    end

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    // The true difference is always below 2^WID, so WID-bit subtraction suffices.
    always_comb begin
        shifted  = {rem_q, quo_q[WID-1]};
        q_bit    = (shifted >= {1'b0, dvs_q});
        rem_step = q_bit ? (shifted[WID-1:0] - dvs_q) : shifted[WID-1:0];
        quo_step = {quo_q[WID-2:0], q_bit};
    end

    // Iteration state: load on start, step while busy, pulse done at the end.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
        end else if (start_i) begin
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            neg_quot_q <= a_neg ^ b_neg;
            neg_rem_q  <= a_neg;
            rem_q      <= '0;
            quo_q      <= a_mag;
            dvs_q      <= b_mag;
        end else if (busy_q) begin
            rem_q <= rem_step;
            quo_q <= quo_step;
            if (cnt_q == CW'(WID - 1)) begin
                cnt_q  <= '0;
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end else begin
            done_q <= 1'b0;
        end
    end

    // Sign fix-up on the final magnitudes.
    always_comb begin
        done_o = done_q;
        quot_o = neg_quot_q ? ('0 - quo_q) : quo_q;
        rem_o  = neg_rem_q  ? ('0 - rem_q) : rem_q;
    end

endmodule
`endif

// File: rtl/thor2022_seq_alu.sv
// Thor2022 sequential ALU: single-request handshake in, held result out.
// Non-divide ops complete one cycle after acceptance; divides (with a
// non-zero divisor) run the iterative divider for WID+1 cycles.
// Optional divider feature macro: THOR2022_SEQ_ALU_DIV_EN. When undefined,
// divide opcodes complete immediately with res=0, res_t=0, dbz=1.
module thor2022_seq_alu
    import thor2022_pkg::*;
#(
    parameter int WID  = 64,
    parameter int TAGW = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      op,
    input  logic [WID-1:0]  a,
    input  logic [WID-1:0]  b,
    input  logic [TAGW-1:0] tag_i,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [WID-1:0]  res,
    output logic [WID-1:0]  res_t,
    output logic [TAGW-1:0] tag_o,
    output logic            dbz
);

    localparam int SHW = $clog2(WID);

    seq_alu_state_t state_q, state_d;
    seq_alu_op_t    op_e;

    logic [WID-1:0]  res_q, res_d;
    logic [WID-1:0]  res_t_q, res_t_d;
    logic [TAGW-1:0] tag_q, tag_d;
    logic            dbz_q, dbz_d;

    logic            accept;
    logic            go_busy;
    logic [WID-1:0]  alu_res;
    logic [WID-1:0]  alu_res_t;
    logic            alu_dbz;

    logic [SHW-1:0]  shamt;
    logic [WID:0]    sum_ext;
    logic [WID:0]    diff_ext;
    logic [2*WID-1:0] sll_full;
    logic [2*WID-1:0] srl_full;
    logic [2*WID-1:0] sra_full;
    logic            lt_s;
    logic            lt_u;

`ifdef THOR2022_SEQ_ALU_DIV_EN
    logic            rem_op_q, rem_op_d;
    logic            div_start;
    logic            div_done;
    logic [WID-1:0]  div_quot;
    logic [WID-1:0]  div_rem;
`endif

    assign op_e   = seq_alu_op_t'(op);
    assign accept = in_valid & in_ready;

    // Shared arithmetic terms; shifts see only the low log2(WID) bits of b.
    always_comb begin
        shamt    = b[SHW-1:0];
        sum_ext  = {1'b0, a} + {1'b0, b};
        diff_ext = {1'b0, a} - {1'b0, b};
        sll_full = {{WID{1'b0}}, a} << shamt;
        srl_full = {a, {WID{1'b0}}} >> shamt;
        sra_full = $signed({a, {WID{1'b0}}}) >>> shamt;
        lt_s     = $signed(a) < $signed(b);
        lt_u     = a < b;
    end

    // Single-cycle result for every op; flags divides that need the iterator.
    always_comb begin
        alu_res   = '0;
        alu_res_t = '0;
        alu_dbz   = 1'b0;
        go_busy   = 1'b0;
        case (op_e)
            OP_ADD: begin
                alu_res   = sum_ext[WID-1:0];
                alu_res_t = {{(WID-1){1'b0}}, sum_ext[WID]};
            end
            OP_SUB: begin
                alu_res   = diff_ext[WID-1:0];
                alu_res_t = {{(WID-1){1'b0}}, diff_ext[WID]};
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_SLL: begin
                alu_res   = sll_full[WID-1:0];
                alu_res_t = sll_full[2*WID-1:WID];
            end
            OP_SRL: begin
                alu_res   = srl_full[2*WID-1:WID];
                alu_res_t = srl_full[WID-1:0];
            end
            OP_SRA: begin
                alu_res   = sra_full[2*WID-1:WID];
                alu_res_t = sra_full[WID-1:0];
            end
            OP_SLT:  alu_res = {{(WID-1){1'b0}}, lt_s};
            OP_SLTU: alu_res = {{(WID-1){1'b0}}, lt_u};
            OP_DIV, OP_DIVU, OP_REM, OP_REMU: begin
`ifdef THOR2022_SEQ_ALU_DIV_EN
                if (b == '0) begin
                    // Divide by zero: quotient all-ones, remainder = dividend.
                    alu_dbz = 1'b1;
                    if (is_rem_op(op_e)) begin
                        alu_res   = a;
                        alu_res_t = '1;
                    end else begin
                        alu_res   = '1;
                        alu_res_t = a;
                    end
                end else begin
                    go_busy = 1'b1;
                end
`else
                alu_dbz = 1'b1;
`endif
            end
            default: begin
                alu_res   = '0;
                alu_res_t = '0;
            end
        endcase
    end

`ifdef THOR2022_SEQ_ALU_DIV_EN
    assign div_start = accept & go_busy;

    thor2022_seq_div #(
        .WID(WID)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (div_start),
        .signed_i (is_signed_div(op_e)),
        .a_i      (a),
        .b_i      (b),
        .done_o   (div_done),
        .quot_o   (div_quot),
        .rem_o    (div_rem)
    );
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: accept from IDLE or from DONE when the result drains.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = go_busy ? ST_BUSY : ST_DONE;
                end
            end
            ST_BUSY: begin
`ifdef THOR2022_SEQ_ALU_DIV_EN
                if (div_done) begin
                    state_d = ST_DONE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_DONE: begin
                if (out_ready) begin
                    if (accept) begin
                        state_d = go_busy ? ST_BUSY : ST_DONE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: ready while idle or while the held result is being taken.
    always_comb begin
        in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
        out_valid = (state_q == ST_DONE);
    end

    // Result next-state: capture immediate results on accept, divider results on done.
    always_comb begin
        res_d   = res_q;
        res_t_d = res_t_q;
        tag_d   = tag_q;
        dbz_d   = dbz_q;
`ifdef THOR2022_SEQ_ALU_DIV_EN
        rem_op_d = rem_op_q;
`endif
        if (accept) begin
            tag_d = tag_i;
            if (!go_busy) begin
                res_d   = alu_res;
                res_t_d = alu_res_t;
                dbz_d   = alu_dbz;
            end
`ifdef THOR2022_SEQ_ALU_DIV_EN
            rem_op_d = is_rem_op(op_e);
`endif
        end
`ifdef THOR2022_SEQ_ALU_DIV_EN
        if ((state_q == ST_BUSY) && div_done) begin
            res_d   = rem_op_q ? div_rem  : div_quot;
            res_t_d = rem_op_q ? div_quot : div_rem;
            dbz_d   = 1'b0;
        end
`endif
    end

    // Result registers, cleared by reset so abandoned work leaves nothing behind.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_q   <= '0;
            res_t_q <= '0;
            tag_q   <= '0;
            dbz_q   <= 1'b0;
`ifdef THOR2022_SEQ_ALU_DIV_EN
            rem_op_q <= 1'b0;
`endif
        end else begin
            res_q   <= res_d;
            res_t_q <= res_t_d;
            tag_q   <= tag_d;
            dbz_q   <= dbz_d;
`ifdef THOR2022_SEQ_ALU_DIV_EN
            rem_op_q <= rem_op_d;
`endif
        end
    end

    assign res   = res_q;
    assign res_t = res_t_q;
    assign tag_o = tag_q;
    assign dbz   = dbz_q;

endmodule

// File: tb/tb_thor2022_seq_alu.sv
// Directed testbench for thor2022_seq_alu (WID=64, TAGW=6).
// Divide expectations follow THOR2022_SEQ_ALU_DIV_EN when it is defined.
module tb_thor2022_seq_alu;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [5:0]  tag_i;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] res;
    logic [63:0] res_t;
    logic [5:0]  tag_o;
    logic        dbz;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    thor2022_seq_alu #(
        .WID  (64),
        .TAGW (6)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .tag_i     (tag_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .res_t     (res_t),
        .tag_o     (tag_o),
        .dbz       (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Issue one request, wait for its result (bounded), check it, then drain it.
    task automatic run_op(input string nm, input logic [3:0] o, input logic [63:0] av,
                          input logic [63:0] bv, input logic [5:0] t,
                          input logic [63:0] er, input logic [63:0] ert,
                          input logic ed, input int el);
        int lat;
        @(negedge clk);
        op = o; a = av; b = bv; tag_i = t; in_valid = 1'b1; out_ready = 1'b0;
        #1;
        chk({nm, ".in_ready"}, in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        $display("txn %-10s op=%0d a=%h b=%h tag=%0d -> res=%h res_t=%h dbz=%b tag=%0d lat=%0d",
                 nm, o, av, bv, t, res, res_t, dbz, tag_o, lat);
        chk({nm, ".lat"},   lat,   el);
        chk({nm, ".res"},   res,   er);
        chk({nm, ".res_t"}, res_t, ert);
        chk({nm, ".dbz"},   dbz,   ed);
        chk({nm, ".tag"},   tag_o, t);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    initial begin
        int seen;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; a = '0; b = '0; tag_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst.in_ready",  in_ready,  1);
        chk("rst.out_valid", out_valid, 0);
        chk("rst.res",       res,       0);
        chk("rst.res_t",     res_t,     0);
        chk("rst.tag",       tag_o,     0);
        chk("rst.dbz",       dbz,       0);

        // Single-cycle operations.
        run_op("add_carry", 4'd0, ONES, 64'd1, 6'd1, 64'd0, 64'd1, 1'b0, 1);
        run_op("add_plain", 4'd0, 64'd40, 64'd2, 6'd2, 64'd42, 64'd0, 1'b0, 1);
        run_op("sub_borrow", 4'd1, 64'd1, 64'd2, 6'd3, ONES, 64'd1, 1'b0, 1);
        run_op("and", 4'd2, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 6'd4,
               64'hF000_F000_F000_F000, 64'd0, 1'b0, 1);
        run_op("or", 4'd3, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 6'd5,
               64'hFFF0_FFF0_FFF0_FFF0, 64'd0, 1'b0, 1);
        run_op("xor", 4'd4, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 6'd6,
               64'h0FF0_0FF0_0FF0_0FF0, 64'd0, 1'b0, 1);
        run_op("sll", 4'd5, 64'h8000_0000_0000_0001, 64'd4, 6'd7, 64'd16, 64'd8, 1'b0, 1);
        run_op("sll_wrap", 4'd5, 64'd1, 64'h41, 6'd8, 64'd2, 64'd0, 1'b0, 1);
        run_op("srl", 4'd6, 64'h8000_0000_0000_0001, 64'h44, 6'd9,
               64'h0800_0000_0000_0000, 64'h1000_0000_0000_0000, 1'b0, 1);
        run_op("sra", 4'd7, 64'h8000_0000_0000_0000, 64'd4, 6'd10,
               64'hF800_0000_0000_0000, 64'd0, 1'b0, 1);
        run_op("slt", 4'd8, ONES, 64'd1, 6'd11, 64'd1, 64'd0, 1'b0, 1);
        run_op("sltu", 4'd9, ONES, 64'd1, 6'd12, 64'd0, 64'd0, 1'b0, 1);
        run_op("op14", 4'd14, 64'd5, 64'd6, 6'd13, 64'd0, 64'd0, 1'b0, 1);
        run_op("op15", 4'd15, ONES, ONES, 6'd14, 64'd0, 64'd0, 1'b0, 1);

`ifdef THOR2022_SEQ_ALU_DIV_EN
        run_op("div_neg", 4'd10, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 6'd20,
               64'hFFFF_FFFF_FFFF_FFFD, ONES, 1'b0, 65);
        run_op("rem_neg", 4'd12, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 6'd21,
               ONES, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 65);
        run_op("divu", 4'd11, 64'd100, 64'd7, 6'd22, 64'd14, 64'd2, 1'b0, 65);
        run_op("remu", 4'd13, 64'd100, 64'd7, 6'd23, 64'd2, 64'd14, 1'b0, 65);
        run_op("divu_dbz", 4'd11, 64'd123, 64'd0, 6'd24, ONES, 64'd123, 1'b1, 1);
        run_op("rem_dbz", 4'd12, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 6'd25,
               64'hFFFF_FFFF_FFFF_FFF9, ONES, 1'b1, 1);
        run_op("div_ovf", 4'd10, 64'h8000_0000_0000_0000, ONES, 6'd26,
               64'h8000_0000_0000_0000, 64'd0, 1'b0, 65);
`else
        run_op("div_off", 4'd10, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 6'd20, 64'd0, 64'd0, 1'b1, 1);
        run_op("divu_off", 4'd11, 64'd123, 64'd0, 6'd21, 64'd0, 64'd0, 1'b1, 1);
        run_op("rem_off", 4'd12, 64'd100, 64'd7, 6'd22, 64'd0, 64'd0, 1'b1, 1);
        run_op("remu_off", 4'd13, 64'd100, 64'd7, 6'd23, 64'd0, 64'd0, 1'b1, 1);
`endif
        // dbz must clear on the next ordinary result.
        run_op("add_after", 4'd0, 64'd7, 64'd8, 6'd27, 64'd15, 64'd0, 1'b0, 1);

        // Back-pressure: hold the result 5 cycles, then back-to-back accept.
        @(negedge clk);
        op = 4'd0; a = 64'd5; b = 64'd3; tag_i = 6'd30; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold.out_valid", out_valid, 1);
            chk("hold.in_ready",  in_ready,  0);
            chk("hold.res",       res,       64'd8);
            chk("hold.tag",       tag_o,     6'd30);
        end
        $display("txn hold       5 cycles stalled with res=%h tag=%0d", res, tag_o);
        @(negedge clk);
        op = 4'd4; a = 64'hAAAA; b = 64'h5555; tag_i = 6'd31;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("b2b.in_ready", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        $display("txn b2b        res=%h tag=%0d out_valid=%b", res, tag_o, out_valid);
        chk("b2b.out_valid", out_valid, 1);
        chk("b2b.res",       res,       64'hFFFF);
        chk("b2b.tag",       tag_o,     6'd31);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;

        // Reset pulsed while an operation is in flight.
        @(negedge clk);
`ifdef THOR2022_SEQ_ALU_DIV_EN
        op = 4'd11; a = 64'd1000; b = 64'd3; tag_i = 6'd40;
`else
        op = 4'd0; a = 64'd1000; b = 64'd3; tag_i = 6'd40;
`endif
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rstmid.out_valid", out_valid, 0);
        chk("rstmid.in_ready",  in_ready,  1);
        chk("rstmid.res",       res,       0);
        chk("rstmid.tag",       tag_o,     0);
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        $display("txn rstmid     abandoned op, out_valid cycles after release=%0d", seen);
        chk("rstmid.no_result", seen, 0);

        // Normal operation resumes after the abandoned request.
        run_op("post_rst", 4'd1, 64'd10, 64'd3, 6'd41, 64'd7, 64'd0, 1'b0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/thor2022_seq_alu.md
THOR2022_SEQ_ALU -- requirements
Module: Thor2022_seq_alu

Interface
REQ-001 SHALL have parameter WID, default 64, meaning operand/result width (power of two, 16..128).
REQ-002 SHALL have parameter TAGW, default 6, meaning width of the caller tag carried with each operation.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  meaning reset, synchronous, active-low.
REQ-005 SHALL have ports in_valid input 1, in_ready output 1, meaning request handshake.
REQ-006 SHALL have ports op input 4, a input WID, b input WID, tag_i input TAGW, meaning the opcode, the two operands and the caller tag.
REQ-007 SHALL have ports out_valid output 1, out_ready input 1, meaning result handshake.
REQ-008 SHALL have ports res output WID, res_t output WID, tag_o output TAGW, dbz output 1, meaning the primary result, the secondary result (carry/spill/remainder), the returned tag and the divide-by-zero flag.

Function
REQ-009 SHALL support opcodes ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9, DIV=10, DIVU=11, REM=12, REMU=13; codes 14-15 SHALL return res=0, res_t=0.
REQ-010 SHALL accept a request on a cycle where in_valid and in_ready are both high; the operands, op and tag SHALL be captured on that edge.
REQ-011 SHALL implement states IDLE, BUSY and DONE.
REQ-012 in_ready SHALL be 1 only in IDLE, or in DONE when out_ready is 1 in the same cycle.
REQ-013 Non-divide ops SHALL go IDLE->DONE with latency 1: out_valid is high the cycle after acceptance.
REQ-014 Divide ops with b!=0 SHALL go IDLE->BUSY, run a radix-2 restoring iteration for exactly WID cycles, then go to DONE (latency WID+1).
REQ-015 DONE SHALL hold res, res_t, tag_o and dbz stable until out_ready=1; on that edge it SHALL go to IDLE, or directly capture a new request if one is accepted in the same cycle (back-to-back, no bubble).
REQ-016 ADD/SUB SHALL give res = WID-bit sum/difference and res_t = {WID-1 zeros, carry/borrow out}.
REQ-017 Shifts SHALL use b[$clog2(WID)-1:0] as the shift amount; res_t SHALL hold the bits shifted out (SLL: upper half of the 2*WID product; SRL/SRA: lower half, with SRA fill = sign of a).
REQ-018 SLT/SLTU SHALL give res = 1 or 0 (signed or unsigned compare) and res_t = 0.
REQ-019 DIV/DIVU SHALL return the quotient in res and the remainder in res_t; REM/REMU SHALL return the remainder in res and the quotient in res_t.
REQ-020 Signed divide SHALL truncate toward zero; the remainder SHALL take the sign of a.
REQ-021 b=0 on a divide op SHALL give latency 1 with quotient all-ones, remainder = a and dbz=1; dbz SHALL be 0 for every other result.
REQ-022 Signed overflow (a = most negative value, b = -1) SHALL give quotient = a, remainder = 0, dbz=0, with the normal WID+1 latency.
REQ-023 in_valid SHALL be ignored while in BUSY; no second divide SHALL be overlapped.

Reset
REQ-024 With rst_n=0 at a clock edge, state SHALL become IDLE, out_valid=0, res=0, res_t=0, tag_o=0, dbz=0 and the iteration counter 0.
REQ-025 Reset during BUSY or DONE SHALL abandon the operation, with no output produced for it.
REQ-026 in_ready SHALL be 1 on the first cycle after reset is released.

Configuration
REQ-027 Macro THOR2022_SEQ_ALU_DIV_EN SHALL, when defined, include the iterative divider and BUSY state.
REQ-028 Without THOR2022_SEQ_ALU_DIV_EN, opcodes 10-13 SHALL complete with latency 1, res=0, res_t=0 and dbz=1, and BUSY SHALL be unreachable.

Structure
REQ-029 The opcode enumeration (seq_alu_op_t) and the state enumeration SHALL live in Thor2022_pkg.
REQ-030 The divider datapath (counter, partial remainder, quotient shift register, sign fix-up) SHALL be a sub-module Thor2022_seq_div with start/done signals.

Verification
REQ-031 ADD, a=64'hFFFF_FFFF_FFFF_FFFF, b=1 -> res=0, res_t=1, out_valid on cycle+1.
REQ-032 DIV, a=-7, b=2 -> res=-3, res_t=-1, out_valid exactly 65 cycles after acceptance (WID=64); REM with the same operands -> res=-1, res_t=-3.
REQ-033 DIVU, b=0, a=123 -> res=all-ones, res_t=123, dbz=1, latency 1.
REQ-034 SRA, a=64'h8000_0000_0000_0000, b=4 -> res=64'hF800_0000_0000_0000, res_t=0; SLL, a=64'h8000_0000_0000_0001, b=4 -> res=16, res_t=8.
REQ-035 out_ready held low 5 cycles in DONE -> outputs stable and in_ready=0; then out_ready=1 with in_valid=1 -> new request captured on the same edge and out_valid stays high the next cycle.
REQ-036 rst_n=0 pulsed mid-BUSY -> out_valid=0 and in_ready=1 on the first cycle after release, with no result emitted for the abandoned divide.
